mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 tb/tb_mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter onto one single-cycle memory port
module mem_port_arbiter (
  input  logic        aclk,
  input  logic        areset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_we,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we
);

  // Owner encoding shared by last_owner and resp_owner.
  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  logic last_owner;
  logic resp_pending;
  logic resp_owner;
  logic grant_i;
  logic grant_d;
  logic read_grant;

  // Byte offsets are dropped: the port is word addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  // Combinational arbitration; the requester that did not win last time wins a tie.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!areset) begin
      if (i_req && d_req) begin
        grant_i = (last_owner == OWNER_DATA);
        grant_d = (last_owner == OWNER_FETCH);
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  // A data grant with no lane enables is a load and needs a response.
  assign read_grant = grant_i || (grant_d && (d_we == 4'h0));

  // Drive the shared port from the winner; everything idles at zero otherwise.
  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_we    = 4'h0;
    if (grant_i) begin
      mem_en   = 1'b1;
      mem_addr = {2'b00, i_addr[31:2]};
    end else if (grant_d) begin
      mem_en    = 1'b1;
      mem_addr  = {2'b00, d_addr[31:2]};
      mem_wdata = d_wdata;
      mem_we    = d_we;
    end
  end

  assign i_gnt = grant_i;
  assign d_gnt = grant_d;

  // Read data is a straight wire from the port; only rvalid qualifies it.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // rvalid is masked during reset so a read granted just before reset never reports.
  assign i_rvalid = !areset && resp_pending && (resp_owner == OWNER_FETCH);
  assign d_rvalid = !areset && resp_pending && (resp_owner == OWNER_DATA);

  // Round-robin history and the one-deep read response tracker.
  always_ff @(posedge aclk) begin
    if (areset) begin
      last_owner   <= OWNER_DATA;
      resp_pending <= 1'b0;
      resp_owner   <= OWNER_FETCH;
    end else begin
      if (grant_i) begin
        last_owner <= OWNER_FETCH;
      end else if (grant_d) begin
        last_owner <= OWNER_DATA;
      end
      resp_pending <= read_grant;
      resp_owner   <= grant_d ? OWNER_DATA : OWNER_FETCH;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        aclk;
  logic        areset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_we;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;

  mem_port_arbiter dut (
    .aclk      (aclk),
    .areset    (areset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_we      (d_we),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we)
  );

  typedef struct {
    logic        owner;
    logic [31:0] data;
  } resp_t;

  resp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic m_last;
  logic last_gi;
  logic last_gd;
  int   i_wait;
  int   d_wait;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [31:0] word_data(input logic [31:0] w);
    return (w * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  // Memory model: read data one cycle after a read enable, noise otherwise.
  always @(posedge aclk) begin
    if (mem_en && mem_we == 4'h0) mem_rdata <= word_data(mem_addr);
    else mem_rdata <= $urandom;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic cycle(input logic rst, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [31:0] da, input logic [3:0] we,
                       input logic [31:0] wd);
    logic        eg_i;
    logic        eg_d;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_we;
    resp_t       e;
    @(posedge aclk);
    #1;
    areset  = rst;
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_addr  = da;
    d_we    = we;
    d_wdata = wd;
    @(negedge aclk);
    if (rst || exp_q.size() == 0) begin
      check_eq("i_rvalid_idle", {31'b0, i_rvalid}, 32'd0);
      check_eq("d_rvalid_idle", {31'b0, d_rvalid}, 32'd0);
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      check_eq("i_rvalid", {31'b0, i_rvalid}, {31'b0, e.owner == 1'b0});
      check_eq("d_rvalid", {31'b0, d_rvalid}, {31'b0, e.owner == 1'b1});
      if (e.owner == 1'b0) check_eq("i_rdata", i_rdata, e.data);
      else check_eq("d_rdata", d_rdata, e.data);
    end
    eg_i = !rst && ir && (!dr || m_last);
    eg_d = !rst && dr && (!ir || !m_last);
    e_addr  = 32'h0;
    e_wdata = 32'h0;
    e_we    = 4'h0;
    if (eg_i) e_addr = {2'b00, ia[31:2]};
    else if (eg_d) begin
      e_addr  = {2'b00, da[31:2]};
      e_wdata = wd;
      e_we    = we;
    end
    check_eq("i_gnt", {31'b0, i_gnt}, {31'b0, eg_i});
    check_eq("d_gnt", {31'b0, d_gnt}, {31'b0, eg_d});
    check_eq("mem_en", {31'b0, mem_en}, {31'b0, eg_i || eg_d});
    check_eq("mem_addr", mem_addr, e_addr);
    check_eq("mem_we", {28'b0, mem_we}, {28'b0, e_we});
    check_eq("mem_wdata", mem_wdata, e_wdata);
    if (rst) m_last = 1'b1;
    else if (eg_i) m_last = 1'b0;
    else if (eg_d) m_last = 1'b1;
    if (eg_i) exp_q.push_back('{owner: 1'b0, data: word_data({2'b00, ia[31:2]})});
    if (eg_d && we == 4'h0) exp_q.push_back('{owner: 1'b1, data: word_data({2'b00, da[31:2]})});
    last_gi = eg_i;
    last_gd = eg_d;
  endtask

  task automatic idle(input logic rst);
    cycle(rst, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    logic        ir;
    logic        dr;
    logic [31:0] ia;
    logic [31:0] da;
    logic [3:0]  we;
    logic [31:0] wd;
    areset = 1'b1; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_addr = 32'h0;
    d_we = 4'h0; d_wdata = 32'h0;
    m_last = 1'b1; last_gi = 1'b0; last_gd = 1'b0; i_wait = 0; d_wait = 0;

    // Reset with both requests active: nothing may be granted.
    cycle(1'b1, 1'b1, 32'h20, 1'b1, 32'h30, 4'hF, 32'h1234_5678);
    idle(1'b1);

    // Single fetch read.
    cycle(1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0, 4'h0, 32'h0);
    check_eq("fetch_addr_const", mem_addr, 32'h4);
    idle(1'b0);

    // Contention after reset: fetch first, then alternate.
    idle(1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, 32'h100 + 32'(k * 4), 1'b1, 32'h200 + 32'(k * 4), 4'h0, 32'h0);
      check_eq("rr_i_gnt", {31'b0, i_gnt}, {31'b0, (k % 2) == 0});
    end
    idle(1'b0);

    // Partial store: byte offset dropped, no response.
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0103, 4'b0011, 32'hA5A5_1234);
    check_eq("store_addr_const", mem_addr, 32'h40);
    check_eq("store_wdata_const", mem_wdata, 32'hA5A5_1234);
    idle(1'b0);

    // Read granted, reset next cycle: response suppressed.
    cycle(1'b0, 1'b1, 32'h0000_0080, 1'b0, 32'h0, 4'h0, 32'h0);
    idle(1'b1);
    idle(1'b0);

    // Request held across reset is re-arbitrated from reset state.
    cycle(1'b1, 1'b1, 32'h44, 1'b1, 32'h48, 4'h0, 32'h0);
    cycle(1'b0, 1'b1, 32'h44, 1'b1, 32'h48, 4'h0, 32'h0);
    cycle(1'b0, 1'b0, 32'h44, 1'b1, 32'h48, 4'h0, 32'h0);
    idle(1'b0);

    // Back-to-back fetch reads.
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    cycle(1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 4'h0, 32'h0);
    cycle(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 4'h0, 32'h0);
    idle(1'b0);

    // Random legal traffic: requests hold until granted.
    ir = 1'b0; dr = 1'b0; ia = 32'h0; da = 32'h0; we = 4'h0; wd = 32'h0;
    last_gi = 1'b0; last_gd = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!(ir && !last_gi)) begin
        ir = 1'($urandom_range(0, 1));
        ia = $urandom;
      end
      if (!(dr && !last_gd)) begin
        dr = 1'($urandom_range(0, 1));
        da = $urandom;
        we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        wd = $urandom;
      end
      cycle(1'b0, ir, ia, dr, da, we, wd);
      if (ir) begin
        if (last_gi) begin
          check_eq("i_wait_bound", {31'b0, i_wait <= 1}, 32'd1);
          i_wait = 0;
        end else i_wait++;
      end
      if (dr) begin
        if (last_gd) begin
          check_eq("d_wait_bound", {31'b0, d_wait <= 1}, 32'd1);
          d_wait = 0;
        end else d_wait++;
      end
    end
    ir = 1'b0; dr = 1'b0;
    idle(1'b0);
    idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
